// File: rtl/cpu_pkg.sv
// cpu_pkg
//   Shared encodings for the 16-bit CPU pipeline control:
//   - fwd_sel_t    : ALU operand source select (register file, EM ALU result, WB data)
//   - MM_*         : memory-mode encodings carried down the pipeline
//   - ctrl_state_t : hazard controller FSM states
//   - timer_w()    : width of the memory-wait down-counter for a given latency
package cpu_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  localparam logic [1:0] MM_NONE = 2'b00;
  localparam logic [1:0] MM_LOAD = 2'b01;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } ctrl_state_t;

  // $clog2(lat) bits, never less than one so the counter always exists.
  function automatic int timer_w(input int lat);
    return (lat > 2) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer
//   Loadable down-counter that measures the remaining data-memory wait cycles.
// Ports
//   clk      in  1  clock
//   rst      in  1  synchronous active-high reset (clears the count)
//   load     in  1  load load_val (has priority over dec)
//   load_val in  W  value loaded on load
//   dec      in  1  decrement by one (holds at zero)
//   zero     out 1  count is zero
module mem_wait_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard and forwarding control for the 5-stage 16-bit CPU pipeline.
//   Freezes the pipeline during multi-cycle data-memory accesses, inserts a
//   one-cycle bubble on load-use, squashes wrong-path work on a taken branch,
//   and selects ALU operand forwarding sources.
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   id_rs1/id_rs2, id_use1/2     Decode source registers and their use flags
//   ex_rs1/ex_rs2, ex_rd         Execute source / destination registers
//   ex_wbs, ex_mm, ex_br_taken   Execute writeback, memory mode, taken branch
//   mem_rd, mem_wbs, mem_mm,     Memory-stage destination, writeback, memory
//   mem_wm                       mode and memory write
//   wb_rd, wb_wbs                Writeback destination and writeback flag
//   stall_f/d/e/m                hold PC / FD / DE / EM registers
//   flush_fd/de/mw               load bubble into FD / DE / MW registers
//   fwdA/fwdB                    ALU operand select (00 RF, 01 EM, 10 WB)
//   busy                         controller is waiting on data memory
//   stall_cycles                 saturating count of cycles with stall_f=1
module pipeline_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int REG_W   = 4,
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic [REG_W-1:0] ex_rs1,
  input  logic [REG_W-1:0] ex_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_wbs,
  input  logic [1:0]       ex_mm,
  input  logic             ex_br_taken,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_wbs,
  input  logic [1:0]       mem_mm,
  input  logic             mem_wm,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_wbs,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_fd,
  output logic             flush_de,
  output logic             flush_mw,
  output logic [1:0]       fwdA,
  output logic [1:0]       fwdB,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int            TW        = timer_w(MEM_LAT);
  localparam bit            MULTI_CYC = (MEM_LAT > 1);
  // The first frozen cycle happens in RUN, so the timer only covers the rest.
  localparam logic [TW-1:0] LOAD_VAL  = TW'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);

  ctrl_state_t state, next_state;
  logic        mem_acc;
  logic        load_use;
  logic        hazard_ok;
  logic        t_load, t_dec, t_zero;
  logic        mem_fwd_ok;
  fwd_sel_t    fwd_a, fwd_b;

  assign mem_acc  = (mem_mm == MM_LOAD) | mem_wm;
  assign load_use = (ex_mm == MM_LOAD) && ex_wbs &&
                    ((id_use1 && (ex_rd == id_rs1)) || (id_use2 && (ex_rd == id_rs2)));

  mem_wait_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (LOAD_VAL),
    .dec      (t_dec),
    .zero     (t_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stall_f && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

  // Branch and load-use are only honoured when the pipeline is not frozen by
  // memory; the release cycle of a wait counts as unfrozen, so a branch or
  // load-use that sat in Execute during the freeze is handled as it advances.
  always_comb begin
    next_state = state;
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    stall_e    = 1'b0;
    stall_m    = 1'b0;
    flush_fd   = 1'b0;
    flush_de   = 1'b0;
    flush_mw   = 1'b0;
    busy       = 1'b0;
    t_load     = 1'b0;
    t_dec      = 1'b0;
    hazard_ok  = 1'b0;
    if (rst) begin
      flush_fd = 1'b1;
      flush_de = 1'b1;
      flush_mw = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (mem_acc && MULTI_CYC) begin
            {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
            flush_mw   = 1'b1;
            t_load     = 1'b1;
            next_state = MEM_WAIT;
          end else begin
            hazard_ok = 1'b1;
          end
        end
        MEM_WAIT: begin
          busy = 1'b1;
          if (!t_zero) begin
            {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
            flush_mw = 1'b1;
            t_dec    = 1'b1;
          end else begin
            next_state = RUN;
            hazard_ok  = 1'b1;
          end
        end
        default: next_state = RUN;
      endcase
      // A taken branch makes the Decode instruction wrong-path, so it wins.
      if (hazard_ok) begin
        if (ex_br_taken) begin
          flush_fd = 1'b1;
          flush_de = 1'b1;
        end else if (load_use) begin
          stall_f  = 1'b1;
          stall_d  = 1'b1;
          flush_de = 1'b1;
        end
      end
    end
  end

  // Load data is not available in Memory, so a load there never forwards.
  assign mem_fwd_ok = mem_wbs && (mem_mm != MM_LOAD);

  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (!rst) begin
      if (mem_fwd_ok && (mem_rd == ex_rs1)) begin
        fwd_a = FWD_MEM;
      end else if (wb_wbs && (wb_rd == ex_rs1)) begin
        fwd_a = FWD_WB;
      end
      if (mem_fwd_ok && (mem_rd == ex_rs2)) begin
        fwd_b = FWD_MEM;
      end else if (wb_wbs && (wb_rd == ex_rs2)) begin
        fwd_b = FWD_WB;
      end
    end
  end

  assign fwdA = fwd_a;
  assign fwdB = fwd_b;

endmodule
